// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic execution unit: opcodes, FSM states and
// the default operand width.
package logic_unit_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOTA = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_SHR  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation core. Shift opcodes yield the zero-extended
// operand A, which is the correct result for a shift amount of zero.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH     = WIDTH_DEF,
    localparam int OUT_WIDTH = 2 * WIDTH
) (
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           opcode,
    output logic [OUT_WIDTH-1:0] result
);

    logic [WIDTH-1:0] bit_res_s;

    // Select the WIDTH-bit operation result
    always_comb begin
        bit_res_s = {WIDTH{1'b0}};
        case (opcode)
            OP_AND:  bit_res_s = in_a & in_b;
            OP_OR:   bit_res_s = in_a | in_b;
            OP_XOR:  bit_res_s = in_a ^ in_b;
            OP_NOTA: bit_res_s = ~in_a;
            OP_NAND: bit_res_s = ~(in_a & in_b);
            OP_NOR:  bit_res_s = ~(in_a | in_b);
            OP_SHL:  bit_res_s = in_a;
            OP_SHR:  bit_res_s = in_a;
            default: bit_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign result = {{WIDTH{1'b0}}, bit_res_s};

endmodule

// File: rtl/logic_exec_unit.sv
// Logic execution unit: single-cycle bitwise ops and bit-serial shifts with a
// valid/ready handshake on both sides.
module logic_exec_unit
    import logic_unit_pkg::*;
#(
    parameter  int WIDTH     = WIDTH_DEF,
    localparam int OUT_WIDTH = 2 * WIDTH,
    localparam int SHW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_logic,
    output logic                 out_zero,
    output logic                 busy
);

    state_t                 state_q, state_d;
    logic [SHW-1:0]         cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   work_q, work_d;
    logic                   dir_q, dir_d;
    logic [OUT_WIDTH-1:0]   out_logic_q, out_logic_d;
    logic                   out_zero_q, out_zero_d;

    logic [OUT_WIDTH-1:0]   core_res_s;
    logic [OUT_WIDTH-1:0]   shifted_s;
    logic [SHW-1:0]         shamt_s;
    logic                   is_shift_s;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .in_a   (in_a),
        .in_b   (in_b),
        .opcode (opcode),
        .result (core_res_s)
    );

    assign shamt_s    = in_b[SHW-1:0];
    assign is_shift_s = (opcode == OP_SHL) || (opcode == OP_SHR);
    // dir_q high selects a right shift
    assign shifted_s  = dir_q ? (work_q >> 1'b1) : (work_q << 1'b1);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dir_d       = dir_q;
        out_logic_d = out_logic_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift_s && (shamt_s != {SHW{1'b0}})) begin
                        state_d = ST_SHIFT;
                        work_d  = {{WIDTH{1'b0}}, in_a};
                        cnt_d   = shamt_s;
                        dir_d   = (opcode == OP_SHR);
                    end else begin
                        state_d     = ST_DONE;
                        out_logic_d = core_res_s;
                        out_zero_d  = (core_res_s == {OUT_WIDTH{1'b0}});
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted_s;
                cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d     = ST_DONE;
                    out_logic_d = shifted_s;
                    out_zero_d  = (shifted_s == {OUT_WIDTH{1'b0}});
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {SHW{1'b0}};
            work_q      <= {OUT_WIDTH{1'b0}};
            dir_q       <= 1'b0;
            out_logic_q <= {OUT_WIDTH{1'b0}};
            out_zero_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            out_logic_q <= out_logic_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_logic = out_logic_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_logic_exec_unit.sv
// Directed self-checking bench for logic_exec_unit (WIDTH = 16).
module tb_logic_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_logic;
    logic        out_zero;
    logic        busy;

    int n_cmp;
    int n_bad;

    logic_exec_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_logic (out_logic),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        in_a     = a;
        in_b     = b;
        opcode   = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out_valid, busy, in_ready, out_zero} !== 4'b0011 || out_logic !== 32'h0) begin
            $display("FAIL reset_state: valid/busy/ready/zero=%b logic=%h, want 0011 logic=0",
                     {out_valid, busy, in_ready, out_zero}, out_logic);
            n_bad++;
        end
    endtask

    task automatic test_bitwise();
        logic [31:0] exp_tab [6];
        exp_tab = '{32'h4, 32'h7, 32'h3, 32'hFFFB, 32'hFFFB, 32'hFFF8};
        out_ready = 1'b1;
        for (int op = 0; op < 6; op++) begin
            issue(16'h0004, 16'h0007, op[2:0]);
            n_cmp++;
            if (out_valid !== 1'b1 || out_logic !== exp_tab[op]) begin
                $display("FAIL bitwise_op%0d: valid=%b logic=%h, want valid=1 logic=%h",
                         op, out_valid, out_logic, exp_tab[op]);
                n_bad++;
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL bitwise_release%0d: ready=%b valid=%b, want 1 0", op, in_ready, out_valid);
                n_bad++;
            end
        end
    endtask

    task automatic run_shift(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                             input int exp_lat, input logic [31:0] exp_val, input string name);
        int cyc;
        int busy_bad;
        out_ready = 1'b1;
        issue(a, b, op);
        cyc = 1;
        busy_bad = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        n_cmp++;
        if (cyc !== exp_lat || out_valid !== 1'b1) begin
            $display("FAIL %s_latency: got %0d cycles (valid=%b), want %0d", name, cyc, out_valid, exp_lat);
            n_bad++;
        end
        n_cmp++;
        if (out_logic !== exp_val || busy_bad != 0) begin
            $display("FAIL %s_value: logic=%h busy_errs=%0d, want %h busy_errs=0", name, out_logic, busy_bad, exp_val);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift();
        run_shift(16'h8001, 16'h0003, 3'd6, 4,  32'h00040008, "shl3");
        run_shift(16'h8000, 16'h000F, 3'd7, 16, 32'h00000001, "shr15");
        run_shift(16'hFFFF, 16'h000F, 3'd6, 16, 32'h7FFF8000, "shl15");
        run_shift(16'h1234, 16'h0000, 3'd6, 1,  32'h00001234, "shl0");
    endtask

    task automatic test_reset_mid_shift();
        int vcount;
        out_ready = 1'b1;
        issue(16'h0001, 16'h000A, 3'd6);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready, out_zero} !== 4'b0011 || out_logic !== 32'h0) begin
            $display("FAIL reset_mid_shift: valid/busy/ready/zero=%b logic=%h, want 0011 logic=0",
                     {out_valid, busy, in_ready, out_zero}, out_logic);
            n_bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) vcount++;
        end
        n_cmp++;
        if (vcount != 0) begin
            $display("FAIL reset_no_pulse: %0d cycles with valid/busy high, want 0", vcount);
            n_bad++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(16'h00FF, 16'h0F0F, 3'd0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_logic !== 32'h0000000F || out_zero !== 1'b0) begin
            $display("FAIL after_reset_and: valid=%b logic=%h zero=%b, want 1 0000000f 0",
                     out_valid, out_logic, out_zero);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int bad;
        out_ready = 1'b0;
        issue(16'h00F0, 16'h0F00, 3'd0);
        bad = 0;
        in_a = 16'hFFFF;
        in_b = 16'h00FF;
        opcode = 3'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_logic !== 32'h0 || out_zero !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0 || out_valid !== 1'b1 || out_logic !== 32'h0 || out_zero !== 1'b1) begin
            $display("FAIL stall_hold: %0d bad cycles, valid=%b logic=%h zero=%b, want 0 1 0 1",
                     bad, out_valid, out_logic, out_zero);
            n_bad++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_logic !== 32'h0) begin
            $display("FAIL stall_release: ready=%b valid=%b logic=%h, want 1 0 0", in_ready, out_valid, out_logic);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        in_a = 16'h0003;
        in_b = 16'h0004;
        opcode = 3'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 16'hFFFF;
        in_b = 16'h0001;
        opcode = 3'd1;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            in_a = in_a ^ 16'h5A5A;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (cyc !== 5 || out_logic !== 32'h00000030) begin
            $display("FAIL ignore_inputs: latency=%0d logic=%h, want 5 00000030", cyc, out_logic);
            n_bad++;
        end
        @(posedge clk);
        #1;
        in_a = 16'h00FF;
        in_b = 16'h0FF0;
        opcode = 3'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_logic !== 32'h00000F0F) begin
            $display("FAIL b2b_first: valid=%b logic=%h, want 1 00000f0f", out_valid, out_logic);
            n_bad++;
        end
        in_a = 16'h0000;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL b2b_gap: valid=%b ready=%b, want 0 1", out_valid, in_ready);
            n_bad++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_logic !== 32'h00000FF0) begin
            $display("FAIL b2b_second: valid=%b logic=%h, want 1 00000ff0", out_valid, out_logic);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 16'h0;
        in_b = 16'h0;
        opcode = 3'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_bitwise();
        test_shift();
        test_reset_mid_shift();
        test_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_exec_unit.md
LOGIC_EXEC_UNIT -- requirements
Module: logic_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits (power of two, >= 4).
REQ-002 Parameter OUT_WIDTH, fixed at 2*WIDTH, result width.
REQ-003 Parameter SHW, fixed at clog2(WIDTH), shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand/opcode presented.
REQ-007 in_ready  output  1  unit can accept an operation this cycle.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shift ops.
REQ-010 opcode  input  3  operation select.
REQ-011 out_valid  output  1  out_logic holds a completed result.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 out_logic  output  OUT_WIDTH  registered result.
REQ-014 out_zero  output  1  registered flag; high when out_logic is all zeros.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NAND, 5 NOR, 6 SHL, 7 SHR (logical).
REQ-017 Bitwise results SHALL be computed on WIDTH bits and zero-extended to OUT_WIDTH (NOT/NAND/NOR upper half = 0).
REQ-018 SHL SHALL yield zero-extended in_a shifted left by shamt within OUT_WIDTH; no bits lost for any shamt 0..WIDTH-1.
REQ-019 SHR SHALL yield zero-extended in_a shifted right by shamt, zero fill.
REQ-020 An operation is accepted on a clock edge where in_valid and in_ready are both high; operands are captured then and later input changes have no effect.
REQ-021 in_ready SHALL be high only in state IDLE.
REQ-022 States: IDLE, SHIFT, DONE.
REQ-023 IDLE -> DONE on accept of opcodes 0-5, or of 6/7 with shamt = 0; result loaded at that edge (out_valid high the next cycle).
REQ-024 IDLE -> SHIFT on accept of 6/7 with shamt > 0; working register loads zero-extended in_a, counter loads shamt.
REQ-025 In SHIFT, working register SHALL shift by exactly one bit per cycle and counter decrement; on the cycle counter is 1, transition to DONE.
REQ-026 Shift latency (accept edge to out_valid high) SHALL be shamt+1 cycles; bitwise latency 1 cycle.
REQ-027 In DONE, out_valid high; out_logic and out_zero SHALL stay stable until out_ready is sampled high, then -> IDLE.
REQ-028 out_logic SHALL hold its last value in IDLE and SHIFT; out_zero updated only when out_logic updates.
REQ-029 Minimum issue interval SHALL be 2 cycles (accept, DONE handshake); no new accept while DONE or SHIFT.
REQ-030 in_valid in SHIFT/DONE SHALL be ignored (not queued).

Reset
REQ-031 rst high SHALL immediately force state IDLE, counter 0, working register 0, out_logic 0, out_zero 1, out_valid 0, busy 0, in_ready 1 (after the rst-driven update, independent of clk).
REQ-032 Reset mid-SHIFT or mid-DONE SHALL discard the operation; no out_valid pulse follows.
REQ-033 First accept is possible on the first rising edge after rst deasserts.

Structure
REQ-034 Opcode encodings, state encoding, and the WIDTH default SHALL live in shared package logic_unit_pkg.
REQ-035 Bitwise ops SHALL be a combinational sub-module logic_op_core (in_a, in_b, opcode -> OUT_WIDTH result); FSM, counter and shift register stay in logic_exec_unit.

Verification
REQ-036 in_a=0x0004, in_b=0x0007, opcodes 0-5 in turn, out_ready=1 -> 0x00000004, 0x00000007, 0x00000003, 0x0000FFFB, 0x0000FFFB, 0x0000FFF8, each 1 cycle after accept.
REQ-037 SHL in_a=0x8001, in_b=0x0003 -> out_logic=0x00040008, out_valid 4 cycles after accept; busy high for those cycles.
REQ-038 SHR in_a=0x8000, in_b=0x000F -> 0x00000001 after 16 cycles; SHL in_a=0x1234, in_b=0 -> 0x00001234 after 1 cycle.
REQ-039 AND in_a=0x00F0, in_b=0x0F00 -> out_logic=0, out_zero=1; out_ready held low 5 cycles -> out_valid and value stable, in_ready low throughout.
REQ-040 SHL in_b=0x000A, rst pulsed on cycle 3 of SHIFT -> all outputs at reset values immediately, no out_valid; next op AND 0x00FF,0x0F0F -> 0x0000000F.
REQ-041 in_valid held high with changing operands during SHIFT -> only the first operation completes; result unchanged by later inputs.
